// File: rtl/asrv32_mem_loader.sv
// asrv32_mem_loader
// Receives a framed program image over a byte stream and writes it into
// memory one 32-bit word at a time, holding the core in reset until a frame
// with a correct checksum has been loaded.
//
// Frame (little-endian):
//   0xA5 | addr[4] | word_count[2] | data[4*N] | checksum
// The checksum is the XOR of every address, count and data byte.
// Inside a frame, 0xA5 is ordinary payload and never causes a resync.

module asrv32_mem_loader #(
    parameter int unsigned MEMORY_DEPTH = 2000,
    parameter logic [31:0] PC_RESET     = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_rx_valid,
    input  logic [7:0]  i_rx_data,
    output logic        o_rx_ready,
    output logic        o_wr_en,
    output logic [31:0] o_data_addr,
    output logic [31:0] o_data_out,
    output logic [3:0]  o_wr_mask,
    output logic        o_cpu_rst_n,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_error,
    output logic [31:0] o_entry_addr
);

    localparam logic [7:0]  MAGIC = 8'hA5;
    localparam logic [33:0] DEPTH = 34'(MEMORY_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_COUNT,
        S_DATA,
        S_WRITE,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    state_t      state;
    logic [1:0]  byte_cnt;    // byte index within the current field
    logic        range_chk;   // COUNT: both count bytes in, window check pending
    logic [31:0] frame_addr;  // start address as received
    logic [31:0] cur_addr;    // address of the next word to write
    logic [15:0] words_left;  // word count, decremented per write
    logic [31:0] word_buf;    // data word being assembled
    logic [7:0]  csum;        // running XOR of addr, count and data bytes

    logic        xfer;
    logic [31:0] word_next;
    logic [33:0] frame_end;
    logic        range_bad;

    assign xfer = i_rx_valid && o_rx_ready;

    // Next assembled word, frame end address and legality of the load window.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch can be inferred.
        word_next = {i_rx_data, word_buf[31:8]};
        frame_end = {2'b00, frame_addr} + {16'b0, words_left, 2'b00};
        range_bad = 1'b0;
        if (frame_addr[1:0] != 2'b00 || frame_end > DEPTH) begin
            range_bad = 1'b1;
        end
    end

    // Frame-parsing state machine; every output is registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments only, so all
            // registers update together from values sampled at the same edge.
            state        <= S_IDLE;
            byte_cnt     <= 2'd0;
            range_chk    <= 1'b0;
            frame_addr   <= 32'd0;
            cur_addr     <= 32'd0;
            words_left   <= 16'd0;
            word_buf     <= 32'd0;
            csum         <= 8'd0;
            o_rx_ready   <= 1'b0;
            o_wr_en      <= 1'b0;
            o_wr_mask    <= 4'b0000;
            o_data_addr  <= 32'd0;
            o_data_out   <= 32'd0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_error      <= 1'b0;
            o_entry_addr <= PC_RESET;
            o_cpu_rst_n  <= 1'b0;
        end else begin
            // The write strobe is a single-cycle pulse; the loader is ready
            // unless it is entering a cycle where it cannot take a byte.
            o_wr_en    <= 1'b0;
            o_wr_mask  <= 4'b0000;
            o_rx_ready <= 1'b1;

            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    // Only the magic byte starts a frame; anything else is dropped.
                    if (xfer && i_rx_data == MAGIC) begin
                        state       <= S_ADDR;
                        byte_cnt    <= 2'd0;
                        range_chk   <= 1'b0;
                        csum        <= 8'd0;
                        o_done      <= 1'b0;
                        o_error     <= 1'b0;
                        o_cpu_rst_n <= 1'b0;
                        o_busy      <= 1'b1;
                    end
                end

                S_ADDR: begin
                    if (xfer) begin
                        frame_addr <= {i_rx_data, frame_addr[31:8]};
                        csum       <= csum ^ i_rx_data;
                        byte_cnt   <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            state    <= S_COUNT;
                            byte_cnt <= 2'd0;
                        end
                    end
                end

                S_COUNT: begin
                    if (range_chk) begin
                        // Window check runs one cycle after the last count byte,
                        // while the stream is held off.
                        range_chk <= 1'b0;
                        cur_addr  <= frame_addr;
                        if (range_bad) begin
                            state   <= S_ERR;
                            o_error <= 1'b1;
                            o_busy  <= 1'b0;
                        end else if (words_left == 16'd0) begin
                            state <= S_CSUM;
                        end else begin
                            state <= S_DATA;
                        end
                    end else if (xfer) begin
                        words_left <= {i_rx_data, words_left[15:8]};
                        csum       <= csum ^ i_rx_data;
                        if (byte_cnt == 2'd1) begin
                            byte_cnt   <= 2'd0;
                            range_chk  <= 1'b1;
                            o_rx_ready <= 1'b0;
                        end else begin
                            byte_cnt <= byte_cnt + 2'd1;
                        end
                    end
                end

                S_DATA: begin
                    if (xfer) begin
                        word_buf <= word_next;
                        csum     <= csum ^ i_rx_data;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            // Present the write in the cycle after the 4th byte.
                            state       <= S_WRITE;
                            byte_cnt    <= 2'd0;
                            o_wr_en     <= 1'b1;
                            o_wr_mask   <= 4'b1111;
                            o_data_addr <= cur_addr;
                            o_data_out  <= word_next;
                            o_rx_ready  <= 1'b0;
                        end
                    end
                end

                S_WRITE: begin
                    // Strobe is on this cycle; advance to the next word.
                    cur_addr   <= cur_addr + 32'd4;
                    words_left <= words_left - 16'd1;
                    if (words_left == 16'd1) begin
                        state <= S_CSUM;
                    end else begin
                        state <= S_DATA;
                    end
                end

                S_CSUM: begin
                    // Release the core only on a matching checksum; writes
                    // already issued stay in memory either way.
                    if (xfer) begin
                        o_busy <= 1'b0;
                        if (i_rx_data == csum) begin
                            state        <= S_DONE;
                            o_done       <= 1'b1;
                            o_entry_addr <= frame_addr;
                            o_cpu_rst_n  <= 1'b1;
                        end else begin
                            state   <= S_ERR;
                            o_error <= 1'b1;
                        end
                    end
                end

                default: begin
                    state  <= S_IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_asrv32_mem_loader.sv
// tb_asrv32_mem_loader
// Drives framed byte streams into the loader and compares captured memory
// writes and final status against a frame-level model of the protocol.

module tb_asrv32_mem_loader;

    localparam int unsigned DEPTH  = 8192;
    localparam logic [31:0] PC_RST = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_rx_valid;
    logic [7:0]  i_rx_data;
    logic        o_rx_ready;
    logic        o_wr_en;
    logic [31:0] o_data_addr;
    logic [31:0] o_data_out;
    logic [3:0]  o_wr_mask;
    logic        o_cpu_rst_n;
    logic        o_busy;
    logic        o_done;
    logic        o_error;
    logic [31:0] o_entry_addr;

    asrv32_mem_loader #(
        .MEMORY_DEPTH(DEPTH),
        .PC_RESET    (PC_RST)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_rx_valid  (i_rx_valid),
        .i_rx_data   (i_rx_data),
        .o_rx_ready  (o_rx_ready),
        .o_wr_en     (o_wr_en),
        .o_data_addr (o_data_addr),
        .o_data_out  (o_data_out),
        .o_wr_mask   (o_wr_mask),
        .o_cpu_rst_n (o_cpu_rst_n),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_error     (o_error),
        .o_entry_addr(o_entry_addr)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Write monitor: capture every strobe, police mask and pulse width.
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int   mask_bad  = 0;
    int   pulse_bad = 0;
    logic prev_wr   = 1'b0;
    bit   mon_en    = 1'b0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (o_wr_en === 1'b1) begin
                wr_addr_q.push_back(o_data_addr);
                wr_data_q.push_back(o_data_out);
                if (prev_wr) pulse_bad++;
            end
            if (o_wr_mask !== (o_wr_en ? 4'b1111 : 4'b0000)) mask_bad++;
            prev_wr = o_wr_en;
        end
    end

    logic [31:0] fw[$];       // data words of the next frame
    logic [31:0] exp_entry;   // model of o_entry_addr

    // Send one byte; gap_mode 0 = back to back, 1 = one idle cycle, 2 = random idle.
    task automatic send_byte(input logic [7:0] b, input int gap_mode);
        int gap;
        bit ok;
        gap = (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(2, 0)) : 0;
        repeat (gap) @(negedge clk);
        i_rx_valid = 1'b1;
        i_rx_data  = b;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (o_rx_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ok) @(posedge clk);
        @(negedge clk);
        i_rx_valid = 1'b0;
        check("rx_accept", ok, 1'b1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst        = 1'b1;
        i_rx_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check("rst_ready",  o_rx_ready,   1'b0);
        check("rst_wr_en",  o_wr_en,      1'b0);
        check("rst_mask",   o_wr_mask,    4'b0000);
        check("rst_addr",   o_data_addr,  32'd0);
        check("rst_data",   o_data_out,   32'd0);
        check("rst_busy",   o_busy,       1'b0);
        check("rst_done",   o_done,       1'b0);
        check("rst_error",  o_error,      1'b0);
        check("rst_entry",  o_entry_addr, PC_RST);
        check("rst_cpu",    o_cpu_rst_n,  1'b0);
        @(negedge clk);
        check("rst_ready1", o_rx_ready,   1'b1);
        exp_entry = PC_RST;
    endtask

    // Build, send and check one frame made of addr and the words in fw.
    task automatic run_frame(input string tag, input logic [31:0] addr, input logic [7:0] csum_flip,
                             input int gap_mode, input bit header_only);
        logic [7:0]  bytes[$];
        logic [7:0]  x;
        logic [31:0] ea[$];
        logic [31:0] ed[$];
        longint unsigned end_a;
        int   n;
        bit   bad_range;
        bit   good;
        n = fw.size();
        bytes = {};
        for (int i = 0; i < 4; i++) bytes.push_back(8'(addr >> (8 * i)));
        bytes.push_back(8'(n));
        bytes.push_back(8'(n >> 8));
        foreach (fw[w]) for (int i = 0; i < 4; i++) bytes.push_back(8'(fw[w] >> (8 * i)));
        x = 8'h00;
        foreach (bytes[i]) x ^= bytes[i];

        end_a     = longint'(addr) + 64'(4 * n);
        bad_range = (addr % 4 != 0) || (end_a > DEPTH);
        good      = !bad_range && (csum_flip == 8'h00);

        wr_addr_q.delete();
        wr_data_q.delete();

        send_byte(8'hA5, gap_mode);
        check({tag, "_cpu_hold"}, o_cpu_rst_n, 1'b0);
        check({tag, "_busy"},     o_busy,      1'b1);
        for (int i = 0; i < 6; i++) send_byte(bytes[i], gap_mode);
        if (!header_only) begin
            for (int i = 6; i < bytes.size(); i++) send_byte(bytes[i], gap_mode);
            send_byte(x ^ csum_flip, gap_mode);
        end
        repeat (4) @(negedge clk);

        if (!bad_range) begin
            for (int i = 0; i < n; i++) begin
                ea.push_back(addr + 32'(4 * i));
                ed.push_back(fw[i]);
            end
        end
        if (good) exp_entry = addr;

        check({tag, "_done"},  o_done,       good);
        check({tag, "_error"}, o_error,      !good);
        check({tag, "_cpu"},   o_cpu_rst_n,  good);
        check({tag, "_idle"},  o_busy,       1'b0);
        check({tag, "_entry"}, o_entry_addr, exp_entry);
        check({tag, "_nwr"},   wr_addr_q.size(), ea.size());
        for (int i = 0; i < ea.size() && i < wr_addr_q.size(); i++) begin
            check({tag, "_wa"}, wr_addr_q[i], ea[i]);
            check({tag, "_wd"}, wr_data_q[i], ed[i]);
        end
    endtask

    initial begin
        int n;
        logic [31:0] a;
        rst        = 1'b1;
        i_rx_valid = 1'b0;
        i_rx_data  = 8'h00;
        exp_entry  = PC_RST;
        repeat (2) @(negedge clk);
        do_reset();
        mon_en = 1'b1;

        // Noise before a frame is ignored, then the reference frame loads.
        send_byte(8'h00, 0);
        send_byte(8'h13, 0);
        check("noise_busy", o_busy, 1'b0);
        fw = {32'h11223344, 32'hAABBCCDD};
        run_frame("good", 32'h0000_1080, 8'h00, 0, 1'b0);

        // Same frame with a corrupted checksum: writes land, error reported.
        run_frame("badsum", 32'h0000_1080, 8'h01, 0, 1'b0);

        // Window violations are rejected after the count; exact fit is legal.
        run_frame("over", DEPTH - 4, 8'h00, 0, 1'b1);
        fw = {32'h1};
        run_frame("misal", 32'h0000_0002, 8'h00, 0, 1'b1);
        fw = {32'hCAFEF00D, 32'h0BADBEEF};
        run_frame("exact", DEPTH - 8, 8'h00, 0, 1'b0);

        // Empty frame.
        fw = {};
        run_frame("empty", 32'h0000_0040, 8'h00, 0, 1'b0);

        // Source toggling valid every other cycle.
        fw = {32'h11223344, 32'hAABBCCDD};
        run_frame("stall", 32'h0000_1080, 8'h00, 1, 1'b0);

        // Magic byte inside the payload is plain data.
        fw = {32'hA5A5A5A5, 32'h000000A5};
        run_frame("magic", 32'h0000_0200, 8'h00, 0, 1'b0);

        // Reset after the third data byte: no write, back to reset values.
        wr_addr_q.delete();
        wr_data_q.delete();
        send_byte(8'hA5, 0);
        send_byte(8'h00, 0); send_byte(8'h03, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
        send_byte(8'h02, 0); send_byte(8'h00, 0);
        send_byte(8'h01, 0); send_byte(8'h02, 0); send_byte(8'h03, 0);
        do_reset();
        repeat (3) @(negedge clk);
        check("midrst_nwr", wr_addr_q.size(), 0);
        fw = {32'h01020304, 32'h05060708};
        run_frame("after_rst", 32'h0000_0300, 8'h00, 0, 1'b0);

        // Randomised frames, with some out-of-window headers.
        for (int f = 0; f < 20; f++) begin
            n  = int'($urandom_range(6, 0));
            fw = {};
            for (int i = 0; i < n; i++) fw.push_back($urandom());
            if (n > 0 && $urandom_range(4, 0) == 0) begin
                a = DEPTH - 32'(4 * n) + 32'(4 * $urandom_range(8, 1));
                run_frame("rnd_over", a, 8'h00, int'($urandom_range(2, 0)), 1'b1);
            end else begin
                a = 32'(4 * $urandom_range((DEPTH / 4) - n, 0));
                run_frame("rnd", a, ($urandom_range(3, 0) == 0) ? 8'($urandom_range(255, 1)) : 8'h00,
                          int'($urandom_range(2, 0)), 1'b0);
            end
        end

        check("mask_rule",    mask_bad,  0);
        check("single_pulse", pulse_bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
